prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Host-side writer for the head controller's instruction and weight memories.
//  Takes a byte stream with a valid/ready handshake and decodes it into commands.
//  Writes 16-bit instruction words ({weightAddr[15:8], opcode[7:0]}) into instr memory.
//  Writes 4x4 tiles of 32-bit elements into weight memory; holds head in reset until RUN.
// PARAMETERS
//  IADDR_W  8   instruction memory address width
//  WADDR_W  8   weight memory address width
//  ELEM_W   32  width of one tile element
//  ELEMS    16  elements per tile (4x4, row-major 11,12,..,44)
// PORTS
//  clk       in   1              clock
//  rst       in   1              synchronous active-high reset
//  in_data   in   8              stream byte
//  in_valid  in   1              in_data valid
//  in_ready  out  1              loader accepts byte this cycle (transfer = valid&ready)
//  im_we     out  1              instr mem write strobe (1-cycle pulse)
//  im_addr   out  IADDR_W        instr mem write address
//  im_wdata  out  16             instr word
//  wm_we     out  1              weight mem write strobe (1-cycle pulse)
//  wm_addr   out  WADDR_W        weight tile address
//  wm_wdata  out  ELEMS*ELEM_W   tile, element 11 in bits [31:0], 44 in top bits
//  head_rst  out  1              reset to head; 1 while loading or not started
//  busy      out  1              FSM not in IDLE
//  err       out  1              sticky: unknown command byte seen
// BEHAVIOUR
//  Reset: FSM=IDLE, in_ready=0, im_we=0, wm_we=0, im_addr=0, im_wdata=0, wm_addr=0,
//   wm_wdata=0, head_rst=1, busy=0, err=0. Reset mid-command aborts; partial data is dropped.
//  Commands (first byte in IDLE):
//   0x01 LOAD_INSTR: addr, cnt, then cnt words as lo,hi byte pairs; cnt=0 means 256 words.
//   0x02 LOAD_TILE: addr, then ELEMS*4 bytes, each element little-endian, in row-major order.
//   0x03 RUN: head_rst<=0 the cycle after the byte is accepted; FSM stays in IDLE.
//   Other bytes: consumed, err<=1 (sticky until rst), FSM stays in IDLE.
//  Any accepted 0x01/0x02 sets head_rst<=1 next cycle; it stays 1 until the next RUN.
//  States: IDLE, I_ADDR, I_CNT, I_LO, I_HI, T_ADDR, T_DATA, T_WR.
//   IDLE -0x01-> I_ADDR -> I_CNT -> I_LO <-> I_HI (loop) -> IDLE after last hi byte.
//   IDLE -0x02-> T_ADDR -> T_DATA (ELEMS*4 bytes) -> T_WR -> IDLE.
//  in_ready=1 in every state except T_WR. No bytes are lost; stalls with in_valid=0 are legal in any state.
//  Instr write: on hi-byte transfer, im_wdata<={hi,lo} and im_we=1 in the next cycle at the current im_addr.
//   im_addr then increments mod 2^IADDR_W; 0xFF wraps to 0x00. No error is flagged on wrap.
//   The remaining-word counter is 9 bits, loaded with cnt (0 -> 256).
//  Tile write: bytes are shifted into the element/byte position given by a 6-bit byte index.
//   T_WR lasts one cycle with wm_we=1 and wm_addr/wm_wdata stable, then returns to IDLE.
//   wm_wdata holds its last value afterwards.
//  Latency: im_we is 1 cycle after the hi-byte transfer. wm_we is 1 cycle after the last tile byte.
//  busy=(state!=IDLE). err does not abort a later valid command.
// TESTING
//  1. rst, then 01 05 02 03 10 07 20 -> im_we @05 data 0x1003, im_we @06 data 0x2007; head_rst=1; busy falls.
//  2. 01 FE 03 + 3 words -> writes at FE, FF, 00 (wrap); cnt=00 -> exactly 256 im_we pulses.
//  3. 02 09 + 64 bytes k=0..63 -> single wm_we, wm_addr=09, element11=0x03020100, element44=0x3F3E3D3C;
//     in_ready=0 only during the T_WR cycle.
//  4. 03 after loads -> head_rst=0 next cycle; a following 01 re-asserts head_rst=1.
//  5. byte 0x7A in IDLE -> err=1, no write strobes; subsequent 03 still clears head_rst; err stays 1.
//  6. rst mid-LOAD_TILE (after 30 bytes) -> no wm_we; back to IDLE; next 02 tile loads cleanly;
//     random in_valid gaps give identical results.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream command decoder that loads instruction words and 4x4 weight tiles
// into the head controller's memories and holds the head in reset until RUN.
module prog_loader #(
  parameter int unsigned IADDR_W = 8,
  parameter int unsigned WADDR_W = 8,
  parameter int unsigned ELEM_W  = 32,
  parameter int unsigned ELEMS   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      im_we,
  output logic [IADDR_W-1:0]        im_addr,
  output logic [15:0]               im_wdata,
  output logic                      wm_we,
  output logic [WADDR_W-1:0]        wm_addr,
  output logic [ELEMS*ELEM_W-1:0]   wm_wdata,
  output logic                      head_rst,
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned TILE_W     = ELEMS * ELEM_W;
  localparam int unsigned TILE_BYTES = TILE_W / 8;
  localparam int unsigned BIDX_W     = $clog2(TILE_BYTES);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(TILE_BYTES - 1);

  localparam logic [7:0] CMD_INSTR = 8'h01;
  localparam logic [7:0] CMD_TILE  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;

  typedef enum logic [2:0] {
    IDLE, I_ADDR, I_CNT, I_LO, I_HI, T_ADDR, T_DATA, T_WR
  } state_t;

  state_t              state, state_d;
  logic                xfer_c;
  logic [7:0]          lo_byte;
  logic [8:0]          remaining;
  logic [BIDX_W-1:0]   byte_idx;
  logic [TILE_W-1:0]   tile_buf;
  logic [TILE_W-1:0]   tile_merge_c;

  assign xfer_c = in_valid & in_ready;

  // Tile buffer with the incoming byte dropped into its slot
  always_comb begin
    tile_merge_c = tile_buf;
    tile_merge_c[{byte_idx, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (xfer_c) begin
          if (in_data == CMD_INSTR)     state_d = I_ADDR;
          else if (in_data == CMD_TILE) state_d = T_ADDR;
        end
      end
      I_ADDR:  if (xfer_c) state_d = I_CNT;
      I_CNT:   if (xfer_c) state_d = I_LO;
      I_LO:    if (xfer_c) state_d = I_HI;
      I_HI:    if (xfer_c) state_d = (remaining == 9'd1) ? IDLE : I_LO;
      T_ADDR:  if (xfer_c) state_d = T_DATA;
      T_DATA:  if (xfer_c && (byte_idx == LAST_BYTE)) state_d = T_WR;
      T_WR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      wm_we     <= 1'b0;
      wm_addr   <= '0;
      wm_wdata  <= '0;
      head_rst  <= 1'b1;
      err       <= 1'b0;
      lo_byte   <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      tile_buf  <= '0;
    end else begin
      in_ready <= (state_d != T_WR);
      busy     <= (state_d != IDLE);
      im_we    <= 1'b0;
      wm_we    <= 1'b0;
      // Address advances in the strobe cycle, so the write sees the old value
      if (im_we) im_addr <= im_addr + 1'b1;
      if (xfer_c) begin
        case (state)
          IDLE: begin
            case (in_data)
              CMD_INSTR, CMD_TILE: head_rst <= 1'b1;
              CMD_RUN:             head_rst <= 1'b0;
              default:             err      <= 1'b1;
            endcase
          end
          I_ADDR: im_addr   <= IADDR_W'(in_data);
          I_CNT:  remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          I_LO:   lo_byte   <= in_data;
          I_HI: begin
            im_we     <= 1'b1;
            im_wdata  <= {in_data, lo_byte};
            remaining <= remaining - 9'd1;
          end
          T_ADDR: begin
            wm_addr  <= WADDR_W'(in_data);
            byte_idx <= '0;
          end
          T_DATA: begin
            tile_buf <= tile_merge_c;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_BYTE) begin
              wm_we    <= 1'b1;
              wm_wdata <= tile_merge_c;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized command
// mix, with expected memory writes produced by a command-level reference model.
module tb_prog_loader;

  localparam int unsigned IADDR_W = 8;
  localparam int unsigned WADDR_W = 8;
  localparam int unsigned ELEM_W  = 32;
  localparam int unsigned ELEMS   = 16;
  localparam int unsigned TILE_W  = ELEMS * ELEM_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 im_we;
  logic [IADDR_W-1:0]   im_addr;
  logic [15:0]          im_wdata;
  logic                 wm_we;
  logic [WADDR_W-1:0]   wm_addr;
  logic [TILE_W-1:0]    wm_wdata;
  logic                 head_rst;
  logic                 busy;
  logic                 err;

  prog_loader #(.IADDR_W(IADDR_W), .WADDR_W(WADDR_W), .ELEM_W(ELEM_W), .ELEMS(ELEMS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .wm_we(wm_we), .wm_addr(wm_addr), .wm_wdata(wm_wdata),
    .head_rst(head_rst), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;
  int nrdy_low = 0;
  logic rst_q = 1'b1;
  logic exp_head = 1'b1;
  logic exp_err  = 1'b0;

  logic [23:0]        exp_iq[$], obs_iq[$];
  logic [WADDR_W-1:0] exp_ta[$], obs_ta[$];
  logic [TILE_W-1:0]  exp_td[$], obs_td[$];

  always @(posedge clk) rst_q <= rst;

  // Capture every write strobe and every not-ready cycle outside reset
  always @(negedge clk) begin
    if (!rst && !rst_q) begin
      if (im_we) obs_iq.push_back({im_addr, im_wdata});
      if (wm_we) begin
        obs_ta.push_back(wm_addr);
        obs_td.push_back(wm_wdata);
      end
      if (!in_ready) nrdy_low++;
    end
  end

  task automatic check(input string tag, input logic [TILE_W-1:0] obs, input logic [TILE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_im_we", im_we, 0);
    check("rst_wm_we", wm_we, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_wm_addr", wm_addr, 0);
    check("rst_wm_wdata", wm_wdata, 0);
    check("rst_head_rst", head_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    exp_head = 1'b1;
    exp_err  = 1'b0;
    obs_iq.delete(); obs_ta.delete(); obs_td.delete();
    exp_iq.delete(); exp_ta.delete(); exp_td.delete();
    @(negedge clk);
  endtask

  task automatic do_instr(input logic [7:0] addr, input logic [7:0] cnt, input logic [15:0] words[$]);
    int n = (cnt == 8'd0) ? 256 : int'(cnt);
    send_byte(8'h01);
    exp_head = 1'b1;
    check("head_rst_on_load", head_rst, 1);
    send_byte(addr);
    send_byte(cnt);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][7:0]);
      send_byte(words[i][15:8]);
      exp_iq.push_back({8'(int'(addr) + i), words[i]});
    end
  endtask

  task automatic do_tile(input logic [7:0] addr, input logic [7:0] bytes[$]);
    logic [TILE_W-1:0] t = '0;
    send_byte(8'h02);
    exp_head = 1'b1;
    check("head_rst_on_tile", head_rst, 1);
    send_byte(addr);
    for (int k = 0; k < 4 * ELEMS; k++) send_byte(bytes[k]);
    for (int e = 0; e < ELEMS; e++)
      t[e*ELEM_W +: ELEM_W] = {bytes[4*e+3], bytes[4*e+2], bytes[4*e+1], bytes[4*e]};
    exp_ta.push_back(addr);
    exp_td.push_back(t);
  endtask

  task automatic do_run();
    send_byte(8'h03);
    exp_head = 1'b0;
    check("head_rst_after_run", head_rst, 0);
  endtask

  task automatic do_bad(input logic [7:0] b);
    send_byte(b);
    exp_err = 1'b1;
    check("err_after_bad", err, 1);
  endtask

  task automatic settle_compare(input string tag);
    int g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_busy_falls"}, busy, 0);
    repeat (2) @(negedge clk);
    check({tag, "_im_count"}, obs_iq.size(), exp_iq.size());
    for (int i = 0; i < exp_iq.size() && i < obs_iq.size(); i++)
      check({tag, "_im_write"}, obs_iq[i], exp_iq[i]);
    check({tag, "_wm_count"}, obs_ta.size(), exp_ta.size());
    for (int i = 0; i < exp_ta.size() && i < obs_ta.size(); i++) begin
      check({tag, "_wm_addr"}, obs_ta[i], exp_ta[i]);
      check({tag, "_wm_data"}, obs_td[i], exp_td[i]);
    end
    check({tag, "_head_rst"}, head_rst, exp_head);
    check({tag, "_err"}, err, exp_err);
    obs_iq.delete(); obs_ta.delete(); obs_td.delete();
    exp_iq.delete(); exp_ta.delete(); exp_td.delete();
  endtask

  initial begin
    logic [15:0] w[$];
    logic [7:0]  tb[$];
    int snap;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_reset();

    // Two-word instruction load from the example stream
    w = '{16'h1003, 16'h2007};
    do_instr(8'h05, 8'h02, w);
    repeat (3) @(negedge clk);
    check("t1_first_word", obs_iq.size() > 0 ? obs_iq[0] : 24'hx, 24'h051003);
    check("t1_second_word", obs_iq.size() > 1 ? obs_iq[1] : 24'hx, 24'h062007);
    settle_compare("t1");

    // Address wrap and cnt=0 meaning 256 words
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back(16'($urandom));
    do_instr(8'hFE, 8'h03, w);
    settle_compare("t2_wrap");
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back(16'($urandom));
    do_instr(8'h80, 8'h00, w);
    settle_compare("t2_256");

    // Ramp tile: check element placement and the single not-ready cycle
    tb.delete();
    for (int k = 0; k < 64; k++) tb.push_back(8'(k));
    snap = nrdy_low;
    do_tile(8'h09, tb);
    repeat (3) @(negedge clk);
    check("t3_wm_addr", obs_ta.size() > 0 ? obs_ta[0] : 8'hx, 8'h09);
    check("t3_elem11", obs_td.size() > 0 ? obs_td[0][31:0] : 32'hx, 32'h03020100);
    check("t3_elem44", obs_td.size() > 0 ? obs_td[0][511:480] : 32'hx, 32'h3F3E3D3C);
    check("t3_nrdy_cycles", nrdy_low - snap, 1);
    settle_compare("t3");
    check("t3_wdata_holds", wm_wdata[31:0], 32'h03020100);

    // RUN releases head, a new load re-asserts it
    do_run();
    w = '{16'hBEEF};
    do_instr(8'h10, 8'h01, w);
    settle_compare("t4");

    // Unknown command byte
    do_bad(8'h7A);
    settle_compare("t5_bad");
    do_run();
    settle_compare("t5_run");
    check("t5_err_sticky", err, 1);

    // Reset in the middle of a tile, then clean tile with random gaps
    send_byte(8'h02);
    send_byte(8'h33);
    for (int k = 0; k < 28; k++) send_byte(8'($urandom));
    do_reset();
    check("t6_idle_after_rst", busy, 0);
    gaps = 1'b1;
    tb.delete();
    for (int k = 0; k < 64; k++) tb.push_back(8'($urandom));
    snap = nrdy_low;
    do_tile(8'h33, tb);
    settle_compare("t6_tile");
    check("t6_nrdy_cycles", nrdy_low - snap, 1);
    w = '{16'h1003, 16'h2007};
    do_instr(8'h05, 8'h02, w);
    settle_compare("t6_gap_instr");

    // Randomized command mix with gaps
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          int n = $urandom_range(1, 6);
          w.delete();
          for (int i = 0; i < n; i++) w.push_back(16'($urandom));
          do_instr(8'($urandom), 8'(n), w);
        end
        1: begin
          tb.delete();
          for (int k = 0; k < 64; k++) tb.push_back(8'($urandom));
          do_tile(8'($urandom), tb);
        end
        2: do_run();
        default: do_bad(8'($urandom_range(4, 255)));
      endcase
      settle_compare("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
